// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the multi-cycle divider: the FSM state encoding and
// the default iteration count (one quotient bit per iteration).
// No ports; imported by div_unit and div_step.
// -----------------------------------------------------------------------------
package div_unit_pkg;

    // One iteration per operand bit.
    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational iteration of a radix-2 restoring divider.
//
// Ports:
//   pr_i           partial remainder from the previous iteration
//   dividendMsb_i  next dividend bit shifted into the partial remainder
//   divisor_i      divisor magnitude
//   prNext_o       partial remainder after this iteration
//   qBit_o         quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_ITER
) (
    input  logic [DATA_W-1:0] pr_i,
    input  logic              dividendMsb_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] prNext_o,
    output logic              qBit_o
);

    // The shifted partial remainder needs one extra bit before the trial
    // subtraction.
    logic [DATA_W:0]   prShift;
    logic [DATA_W-1:0] diffLow;

    assign prShift = {pr_i, dividendMsb_i};

    // The trial difference is only kept when it is non-negative, and then it is
    // below the divisor (or, for a zero divisor, no larger than the dividend
    // bits consumed so far), so the low DATA_W bits hold it exactly.
    assign qBit_o   = (prShift >= {1'b0, divisor_i});
    assign diffLow  = prShift[DATA_W-1:0] - divisor_i;
    assign prNext_o = qBit_o ? diffLow : prShift[DATA_W-1:0];

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle integer divider for DIV/DIVU. Accepts operands on a valid/ready
// handshake, runs a restoring loop (one quotient bit per cycle), applies the
// sign fixup, then offers quotient (LO) and remainder (HI) on a second
// valid/ready handshake.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   div_valid / div_ready  operand handshake (ready only while idle)
//   div_signed             1 = DIV (two's complement), 0 = DIVU
//   div_src1 / div_src2    dividend / divisor, sampled at acceptance only
//   cancel                 abort whatever is in flight, back to idle
//   res_valid / res_ready  result handshake
//   quotient / remainder   registered results, held until consumed
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_ITER
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] div_src1,
    input  logic [DATA_W-1:0] div_src2,
    input  logic              cancel,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] dividend_q;
    logic [DATA_W-1:0] divisor_q;
    logic [DATA_W-1:0] pr_q;
    logic              qNeg_q;
    logic              rNeg_q;
    logic [DATA_W-1:0] quotient_q;
    logic [DATA_W-1:0] remainder_q;

    logic              accept;
    logic [DATA_W-1:0] absSrc1;
    logic [DATA_W-1:0] absSrc2;
    logic [DATA_W-1:0] prNext;
    logic              qBit;

    assign accept = (state_q == IDLE) && div_valid && !cancel;

    // Magnitudes for DIV; the most negative value maps onto itself, which is
    // still the right unsigned magnitude.
    assign absSrc1 = (div_signed && div_src1[DATA_W-1]) ? (~div_src1 + 1'b1) : div_src1;
    assign absSrc2 = (div_signed && div_src2[DATA_W-1]) ? (~div_src2 + 1'b1) : div_src2;

    div_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .pr_i          (pr_q),
        .dividendMsb_i (dividend_q[DATA_W-1]),
        .divisor_i     (divisor_q),
        .prNext_o      (prNext),
        .qBit_o        (qBit)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cancel overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (cancel) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (div_valid) state_d = CALC;
                CALC: if (count_q == LAST_ITER) state_d = FIX;
                FIX:  state_d = DONE;
                DONE: if (res_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake outputs depend on state only.
    always_comb begin
        div_ready = (state_q == IDLE);
        res_valid = (state_q == DONE);
    end

    // Datapath. The dividend register doubles as the quotient: each iteration
    // shifts the consumed dividend bit out of the top and the new quotient
    // bit in at the bottom, so after DATA_W iterations it holds the quotient
    // and pr_q holds the remainder.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q     <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            pr_q        <= '0;
            qNeg_q      <= 1'b0;
            rNeg_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        dividend_q <= absSrc1;
                        divisor_q  <= absSrc2;
                        pr_q       <= '0;
                        count_q    <= '0;
                        qNeg_q     <= div_signed && (div_src1[DATA_W-1] ^ div_src2[DATA_W-1]);
                        rNeg_q     <= div_signed && div_src1[DATA_W-1];
                    end
                end
                CALC: begin
                    pr_q       <= prNext;
                    dividend_q <= {dividend_q[DATA_W-2:0], qBit};
                    count_q    <= count_q + 1'b1;
                end
                FIX: begin
                    if (!cancel) begin
                        quotient_q  <= qNeg_q ? (~dividend_q + 1'b1) : dividend_q;
                        remainder_q <= rNeg_q ? (~pr_q + 1'b1) : pr_q;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Directed bench for div_unit: reset state, signed/unsigned quotients and
// remainders, divide by zero, the most-negative/-1 case, result back-pressure,
// cancel against a same-cycle request, and asynchronous reset mid-operation.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        cancel;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks;
    int failures;

    div_unit #(
        .DATA_W(32)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .cancel     (cancel),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present a request at the current point (just after an edge) and let the
    // next edge accept it; afterwards scramble the operands, which must be
    // ignored from then on.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        div_valid  = 1'b1;
        div_signed = sgn;
        div_src1   = a;
        div_src2   = b;
        @(posedge clk);
        #1;
        div_valid  = 1'b0;
        div_signed = ~sgn;
        div_src1   = $urandom;
        div_src2   = $urandom;
    endtask

    // Called just after the acceptance edge: waits (bounded) for res_valid and
    // checks latency, results and that the unit is still busy.
    task automatic waitResult(input string tag, input logic [31:0] expQ,
                              input logic [31:0] expR);
        int cyc;
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput({tag, "_latency"}, 32'(cyc), 32'd33);
        checkOutput({tag, "_quotient"}, quotient, expQ);
        checkOutput({tag, "_remainder"}, remainder, expR);
        checkOutput({tag, "_busy"}, {31'd0, div_ready}, 32'd0);
    endtask

    // Full operation with res_ready high: result consumed on the edge after it
    // appears, unit idle again right after.
    task automatic runOp(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expQ,
                         input logic [31:0] expR);
        applyStimulus(sgn, a, b);
        checkOutput({tag, "_ready_low"}, {31'd0, div_ready}, 32'd0);
        waitResult(tag, expQ, expR);
        @(posedge clk);
        #1;
        checkOutput({tag, "_consumed_valid"}, {31'd0, res_valid}, 32'd0);
        checkOutput({tag, "_consumed_ready"}, {31'd0, div_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stableErr;

        checks     = 0;
        failures   = 0;
        resetn     = 1'b0;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        div_src1   = '0;
        div_src2   = '0;
        cancel     = 1'b0;
        res_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", {31'd0, div_ready}, 32'd1);
        checkOutput("rst_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_quotient", quotient, 32'd0);
        checkOutput("rst_remainder", remainder, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic quotients");
        runOp("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        runOp("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        runOp("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        runOp("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        runOp("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        // Signed by zero: |-5|/0 gives all-ones, then both results negated.
        runOp("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB);
        runOp("divu_max_3", 1'b0, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'd0);
        // Same bit pattern as DIV: unsigned treats it as a large positive.
        runOp("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1);

        $display("[TB] result back-pressure");
        res_ready = 1'b0;
        applyStimulus(1'b0, 32'd50, 32'd6);
        waitResult("bp", 32'd8, 32'd2);
        div_valid  = 1'b1;
        div_signed = 1'b0;
        div_src1   = 32'd9;
        div_src2   = 32'd3;
        stableErr  = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (res_valid !== 1'b1 || quotient !== 32'd8 || remainder !== 32'd2
                || div_ready !== 1'b0)
                stableErr++;
        end
        checkOutput("bp_stable", 32'(stableErr), 32'd0);
        div_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_consumed_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("bp_consumed_ready", {31'd0, div_ready}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("bp_no_accept", {31'd0, div_ready}, 32'd1);

        $display("[TB] cancel with same-cycle request");
        applyStimulus(1'b0, 32'd1000, 32'd10);
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        cancel     = 1'b1;
        div_valid  = 1'b1;
        div_signed = 1'b0;
        div_src1   = 32'd20;
        div_src2   = 32'd3;
        @(posedge clk);
        #1;
        checkOutput("cancel_idle", {31'd0, div_ready}, 32'd1);
        checkOutput("cancel_valid", {31'd0, res_valid}, 32'd0);
        cancel = 1'b0;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        div_src1  = 32'hDEAD_BEEF;
        div_src2  = 32'h1234_5678;
        checkOutput("cancel_retry_taken", {31'd0, div_ready}, 32'd0);
        waitResult("cancel_20_3", 32'd6, 32'd2);
        @(posedge clk);
        #1;
        checkOutput("cancel_done_ready", {31'd0, div_ready}, 32'd1);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 32'd1000, 32'd7);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #3;
        resetn = 1'b0;
        #1;
        checkOutput("arst_ready", {31'd0, div_ready}, 32'd1);
        checkOutput("arst_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("arst_quotient", quotient, 32'd0);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        runOp("post_rst_1000_7", 1'b0, 32'd1000, 32'd7, 32'd142, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
